// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade/PWM stage: LED count, level container
// type and the gamma mapping used when LED_FADE_GAMMA_EN is defined.
package led_pkg;

  localparam int LedCount  = 8;
  localparam int LevelMaxW = 16;

  // Wide container for a brightness level; modules narrow it to PWM_BITS.
  typedef logic [LevelMaxW-1:0] led_level_t;

  // Perceptual mapping: square the level and drop PWM_BITS bits. Full scale
  // is pinned to full scale so a solid LED never flickers off for one clock.
  function automatic led_level_t gamma_map(input led_level_t level,
                                           input int unsigned bits);
    logic [2*LevelMaxW-1:0] sq;
    led_level_t             max_lvl;
    max_lvl = led_level_t'((32'd1 << bits) - 32'd1);
    sq      = {{LevelMaxW{1'b0}}, level} * {{LevelMaxW{1'b0}}, level};
    if (level == max_lvl) begin
      return max_lvl;
    end
    return led_level_t'(sq >> bits);
  endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / PWM-out bundle between the LED sequencer, the fade stage and
// the board pins. The sequencer side is the master.
interface led_fade_pwm_if;

  logic [led_pkg::LedCount-1:0] led_pattern_i;
  logic [led_pkg::LedCount-1:0] led_display_o;
  logic                         pwm_frame_o;

  modport master (
    output led_pattern_i,
    input  led_display_o,
    input  pwm_frame_o
  );

  modport slave (
    input  led_pattern_i,
    output led_display_o,
    output pwm_frame_o
  );

endinterface

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness level with linear decay, frame-aligned duty
// latch and registered PWM compare. With LED_FADE_GAMMA_EN defined the duty
// is the squared (gamma) level; otherwise the level is used directly.
module led_pwm_channel #(
  parameter int   PWM_BITS         = 8,
  parameter int   DECAY_STEP       = 8,
  parameter logic LED_OUT_POLARITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic                decay_tick,
  input  logic                frame_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  import led_pkg::*;

  typedef logic [PWM_BITS-1:0] level_t;

  localparam level_t LevelMax = '1;
  localparam level_t Step     = level_t'(DECAY_STEP);

  level_t level;
  level_t level_next;
  level_t duty_next;
  level_t duty_q;

  // Saturating decrement: a level at or below the step lands on zero.
  function automatic level_t sat_sub(input level_t val, input level_t step);
    return (val > step) ? level_t'(val - step) : '0;
  endfunction

  // Level priority: active bit, then decay tick, otherwise hold.
  always_comb begin
    level_next = level;
    if (active) begin
      level_next = LevelMax;
    end else if (decay_tick) begin
      level_next = sat_sub(level, Step);
    end
  end

  // Brightness level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      level <= level_next;
    end
  end

  // Duty mapping applied at the frame boundary.
  always_comb begin
`ifdef LED_FADE_GAMMA_EN
    duty_next = level_t'(gamma_map(led_level_t'(level), int unsigned'(PWM_BITS)));
`else
    duty_next = level;
`endif
  end

  // Duty only changes on the last count of a frame, so frames never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (frame_end) begin
      duty_q <= duty_next;
    end
  end

  // Registered compare: full scale is solid on, otherwise duty_q clocks on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= ~LED_OUT_POLARITY;
    end else if ((duty_q == LevelMax) || (pwm_cnt < duty_q)) begin
      led <= LED_OUT_POLARITY;
    end else begin
      led <= ~LED_OUT_POLARITY;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade/PWM stage behind the 8-LED sequencer. Owns the pattern capture
// register, the decay prescaler, the shared PWM counter and the frame pulse;
// each LED's level/duty/compare lives in led_pwm_channel.
// Optional feature macro: LED_FADE_GAMMA_EN (gamma-mapped duty in channels).
module led_fade_pwm #(
  parameter int   CLK_IN_MHZ       = 125,
  parameter int   PWM_BITS         = 8,
  parameter int   DECAY_US         = 2000,
  parameter int   DECAY_STEP       = 8,
  parameter logic LED_IN_POLARITY  = 1'b0,
  parameter logic LED_OUT_POLARITY = 1'b0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  led_fade_pwm_if.slave     bus
);
  import led_pkg::*;

  typedef logic [PWM_BITS-1:0] level_t;

  localparam int DecayCycles = CLK_IN_MHZ * DECAY_US;
  localparam int PrescW      = (DecayCycles > 1) ? $clog2(DecayCycles) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(DecayCycles - 1);
  localparam level_t PwmMax = '1;

  logic [LedCount-1:0] pattern_q;
  logic [LedCount-1:0] active;
  logic [LedCount-1:0] display;
  logic [PrescW-1:0]   presc;
  logic                decay_tick;
  level_t              pwm_cnt;
  logic                frame_end;
  logic                pwm_frame_q;

  assign decay_tick = (presc == PrescLast);
  assign frame_end  = (pwm_cnt == PwmMax);

  // Same-domain pattern capture; reset to all-inactive.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pattern_q <= {LedCount{~LED_IN_POLARITY}};
    end else begin
      pattern_q <= bus.led_pattern_i;
    end
  end

  // Bit i is lit while it matches the sequencer's active level.
  always_comb begin
    active = '0;
    for (int i = 0; i < LedCount; i++) begin
      active[i] = (pattern_q[i] == LED_IN_POLARITY);
    end
  end

  // Decay prescaler: one-cycle tick at the terminal count, then back to 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc <= '0;
    end else if (decay_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Free-running PWM counter; natural wrap at full scale.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Frame pulse lines up with the last output clock of each frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_frame_q <= 1'b0;
    end else begin
      pwm_frame_q <= frame_end;
    end
  end

  for (genvar i = 0; i < LedCount; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS         (PWM_BITS),
      .DECAY_STEP       (DECAY_STEP),
      .LED_OUT_POLARITY (LED_OUT_POLARITY)
    ) u_ch (
      .clk        (clk_i),
      .rst_n      (rstn_i),
      .active     (active[i]),
      .decay_tick (decay_tick),
      .frame_end  (frame_end),
      .pwm_cnt    (pwm_cnt),
      .led        (display[i])
    );
  end

  assign bus.led_display_o = display;
  assign bus.pwm_frame_o   = pwm_frame_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: 1 MHz clock, 8 us decay period (tick every
// 8 clocks), 4-bit PWM (16-clock frames), step 3, active-low in, active-high out.
module tb_led_fade_pwm;

  logic       clk;
  logic       rstn;
  logic [7:0] pattern;
  int         checks;
  int         failures;
  int         cyc;

  led_fade_pwm_if bus ();
  assign bus.led_pattern_i = pattern;

  led_fade_pwm #(
    .CLK_IN_MHZ       (1),
    .PWM_BITS         (4),
    .DECAY_US         (8),
    .DECAY_STEP       (3),
    .LED_IN_POLARITY  (1'b0),
    .LED_OUT_POLARITY (1'b1)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick();
  endtask

  function automatic int lvl0();
    return int'(dut.g_ch[0].u_ch.level);
  endfunction

  // Expected per-frame on-clocks of bit 0 during the fade (duty 15,12,6,0).
`ifdef LED_FADE_GAMMA_EN
  int exp_on[4] = '{16, 9, 2, 0};
`else
  int exp_on[4] = '{16, 12, 6, 0};
`endif
  int exp_lvl[5] = '{12, 9, 6, 3, 0};

  initial begin
    int pulses;
    int first_pulse;
    int disp_or;
    int on0;
    int other;
    int on_cnt[4];

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rstn     = 1'b0;
    pattern  = 8'hFF;

    // Reset held: outputs at their off values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_display", int'(bus.led_display_o), 8'h00);
    check("reset_frame", int'(bus.pwm_frame_o), 0);
    rstn = 1'b1;
    cyc  = 0;

    // Frame pulse every 16 clocks, first after edge 16; LEDs stay dark.
    pulses      = 0;
    first_pulse = -1;
    disp_or     = 0;
    repeat (48) begin
      tick();
      disp_or |= int'(bus.led_display_o);
      if (bus.pwm_frame_o) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
      end
    end
    check("frame_pulses", pulses, 3);
    check("first_pulse_cycle", first_pulse, 16);
    check("idle_display", disp_or, 0);

    // Steady active bit 0: duty latched at edge 64, frame 65..80 solid on.
    pattern = 8'hFE;
    tick_until(64);
    check("frame_at_64", int'(bus.pwm_frame_o), 1);
    on0   = 0;
    other = 0;
    repeat (16) begin
      tick();
      on0   += int'(bus.led_display_o[0]);
      other |= int'(bus.led_display_o[7:1]);
    end
    check("steady_on_count", on0, 16);
    check("steady_other_bits", other, 0);

    // Fade: ticks at edges 88..120 give 12,9,6,3,0; frames use duty 15,12,6,0.
    pattern = 8'hFF;
    for (int f = 0; f < 4; f++) on_cnt[f] = 0;
    repeat (64) begin
      tick();
      on_cnt[(cyc - 81) / 16] += int'(bus.led_display_o[0]);
      if ((cyc % 8 == 0) && (cyc >= 88) && (cyc <= 120))
        check($sformatf("fade_level_c%0d", cyc), lvl0(), exp_lvl[(cyc - 88) / 8]);
    end
    for (int f = 0; f < 4; f++)
      check($sformatf("fade_on_frame%0d", f), on_cnt[f], exp_on[f]);

    // Re-assert bit 0 so it is active exactly on the tick edge 168 at level 9.
    pattern = 8'hFE;
    tick_until(146);
    pattern = 8'hFF;
    tick_until(166);
    pattern = 8'hFE;
    tick();
    check("pre_collision_level", lvl0(), 9);
    check("collision_tick_high", int'(dut.decay_tick), 1);
    tick();
    check("collision_level", lvl0(), 15);

    // Mid-fade asynchronous reset between clock edges.
    pattern = 8'hFF;
    tick_until(180);
    check("lit_before_reset", int'(bus.led_display_o[0]), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_display", int'(bus.led_display_o), 8'h00);
    check("async_reset_frame", int'(bus.pwm_frame_o), 0);
    check("async_reset_level", lvl0(), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
    disp_or = 0;
    repeat (20) begin
      tick();
      disp_or |= int'(bus.led_display_o);
    end
    check("post_reset_level", lvl0(), 0);
    check("post_reset_display", disp_or, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
